// File: rtl/mac_pkg.sv
// Shared types and sizes for the MAC sequencer: FSM states,
// datapath widths, drain lengths and the MAC control bundle.
package mac_pkg;

  localparam int LEN_W            = 4;
  localparam int OP_W             = 8;
  localparam int ACC_W            = 16;
  localparam int DRAIN_LEN_DIRECT = 1;
  localparam int DRAIN_LEN_OPREG  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_e;

  typedef struct packed {
    logic            en;
    logic            rst;
    logic [OP_W-1:0] bias;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } mac_ctl_t;

endpackage

// File: rtl/mac_seq_opreg.sv
// One-stage register for the MAC control bundle.
// Ports: clk, rst (sync, high), ctl_i -> ctl_o one cycle later.
module mac_seq_opreg
  import mac_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  mac_ctl_t ctl_i,
  output mac_ctl_t ctl_o
);

  mac_ctl_t ctl_d, ctl_q;

  always_comb ctl_d = ctl_i;

  always_ff @(posedge clk) begin
    if (rst) ctl_q <= '0;
    else     ctl_q <= ctl_d;
  end

  assign ctl_o = ctl_q;

endmodule

// File: rtl/mac_sequencer.sv
// Sequencer feeding a bias-seeded MAC: LOAD, LEN operand beats, result.
// Ports: CLKEXT/RST_SEQ, START/LEN/BIAS job, OP_* operand handshake,
// EN_MAC/RST_MAC/BIAS_IN/A/B to MAC, MAC_Y back, RES_* result, BUSY.
// Build option MAC_SEQ_OPREG_EN registers the MAC controls (+1 drain).
module mac_sequencer
  import mac_pkg::*;
(
  input  logic             CLKEXT,
  input  logic             RST_SEQ,
  input  logic             START,
  input  logic [LEN_W-1:0] LEN,
  input  logic [OP_W-1:0]  BIAS,
  input  logic             OP_VALID,
  input  logic [OP_W-1:0]  OP_A,
  input  logic [OP_W-1:0]  OP_B,
  output logic             OP_READY,
  output logic             EN_MAC,
  output logic             RST_MAC,
  output logic [OP_W-1:0]  BIAS_IN,
  output logic [OP_W-1:0]  A,
  output logic [OP_W-1:0]  B,
  input  logic [ACC_W-1:0] MAC_Y,
  output logic             RES_VALID,
  output logic [ACC_W-1:0] RES_DATA,
  input  logic             RES_READY,
  output logic             BUSY
);

`ifdef MAC_SEQ_OPREG_EN
  localparam int DRAIN_LEN = DRAIN_LEN_OPREG;
`else
  localparam int DRAIN_LEN = DRAIN_LEN_DIRECT;
`endif
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_LEN - 1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [OP_W-1:0]  bias_q, bias_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [1:0]       drain_q, drain_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             accept;
  mac_ctl_t         ctl;
  mac_ctl_t         mac_o;

  assign accept  = (state_q == S_ACC) && OP_VALID;
  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    bias_d      = bias_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    drain_d     = drain_q;
    ctl         = '0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (START) begin
          len_d   = LEN;
          bias_d  = BIAS;
          state_d = S_LOAD;
        end
      end
      (state_q == S_LOAD): begin
        ctl.en   = 1'b1;
        ctl.rst  = 1'b1;
        ctl.bias = bias_q;
        cnt_d    = '0;
        drain_d  = '0;
        state_d  = (len_q == '0) ? S_DRAIN : S_ACC;
      end
      (state_q == S_ACC): begin
        if (accept) begin
          ctl.en = 1'b1;
          ctl.a  = OP_A;
          ctl.b  = OP_B;
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) state_d = S_DRAIN;
        end
      end
      (state_q == S_DRAIN): begin
        // MAC_Y only settles once the last beat has left the pipe.
        if (drain_q == DRAIN_LAST) begin
          res_d       = MAC_Y;
          res_valid_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      (state_q == S_DONE): begin
        if (RES_READY) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKEXT) begin
    if (RST_SEQ) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      bias_q      <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      bias_q      <= bias_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      drain_q     <= drain_d;
    end
  end

`ifdef MAC_SEQ_OPREG_EN
  mac_seq_opreg u_opreg (
    .clk   (CLKEXT),
    .rst   (RST_SEQ),
    .ctl_i (ctl),
    .ctl_o (mac_o)
  );
`else
  assign mac_o = ctl;
`endif

  assign EN_MAC    = mac_o.en;
  assign RST_MAC   = mac_o.rst;
  assign BIAS_IN   = mac_o.bias;
  assign A         = mac_o.a;
  assign B         = mac_o.b;
  assign OP_READY  = (state_q == S_ACC);
  assign BUSY      = (state_q != S_IDLE);
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench: mac_sequencer paired with a saturating MAC model.
// Checks reset, jobs, bubbles, saturation, backpressure, mid-op reset.
module tb_mac_sequencer;

`ifdef MAC_SEQ_OPREG_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        CLKEXT = 1'b0;
  logic        RST_SEQ = 1'b1;
  logic        START = 1'b0;
  logic [3:0]  LEN = '0;
  logic [7:0]  BIAS = '0;
  logic        OP_VALID = 1'b0;
  logic [7:0]  OP_A = '0;
  logic [7:0]  OP_B = '0;
  logic        OP_READY;
  logic        EN_MAC;
  logic        RST_MAC;
  logic [7:0]  BIAS_IN;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] MAC_Y;
  logic        RES_VALID;
  logic [15:0] RES_DATA;
  logic        RES_READY = 1'b0;
  logic        BUSY;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int en_cnt = 0;
  int rdy_cnt = 0;

  mac_sequencer dut (
    .CLKEXT    (CLKEXT),
    .RST_SEQ   (RST_SEQ),
    .START     (START),
    .LEN       (LEN),
    .BIAS      (BIAS),
    .OP_VALID  (OP_VALID),
    .OP_A      (OP_A),
    .OP_B      (OP_B),
    .OP_READY  (OP_READY),
    .EN_MAC    (EN_MAC),
    .RST_MAC   (RST_MAC),
    .BIAS_IN   (BIAS_IN),
    .A         (A),
    .B         (B),
    .MAC_Y     (MAC_Y),
    .RES_VALID (RES_VALID),
    .RES_DATA  (RES_DATA),
    .RES_READY (RES_READY),
    .BUSY      (BUSY)
  );

  always #5 CLKEXT = ~CLKEXT;

  // Saturating MAC model; controls snapshot mid-cycle to avoid edge races.
  logic [15:0] acc = '0;
  logic        s_en = 1'b0;
  logic        s_rst = 1'b0;
  logic [7:0]  s_bias = '0;
  logic [7:0]  s_a = '0;
  logic [7:0]  s_b = '0;

  function automatic logic [15:0] mac_step(logic [15:0] y, logic [7:0] a,
                                           logic [7:0] b);
    int t;
    t = int'($signed(y)) + int'($signed(a)) * int'($signed(b));
    if (t > 32767)  t = 32767;
    if (t < -32768) t = -32768;
    return 16'(t);
  endfunction

  always @(negedge CLKEXT) begin
    s_en   <= EN_MAC;
    s_rst  <= RST_MAC;
    s_bias <= BIAS_IN;
    s_a    <= A;
    s_b    <= B;
    if (EN_MAC === 1'b1)   en_cnt  <= en_cnt + 1;
    if (OP_READY === 1'b1) rdy_cnt <= rdy_cnt + 1;
  end

  always @(posedge CLKEXT) begin
    cyc <= cyc + 1;
    if (s_en === 1'b1) begin
      if (s_rst) acc <= {8'h00, s_bias};
      else       acc <= mac_step(acc, s_a, s_b);
    end
  end

  assign MAC_Y = acc;

  task automatic tick();
    @(posedge CLKEXT);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [3:0] l, input logic [7:0] b);
    en_cnt  = 0;
    rdy_cnt = 0;
    START = 1'b1;
    LEN   = l;
    BIAS  = b;
    tick();
    START = 1'b0;
  endtask

  task automatic feed_op(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    OP_VALID = 1'b1;
    OP_A     = a;
    OP_B     = b;
    #1;
    while (!OP_READY && k < 20) begin
      tick();
      #1;
      k++;
    end
    if (k == 20) chk("op_ready_wait", OP_READY, 1);
    acc_cyc = cyc;
    tick();
    OP_VALID = 1'b0;
    OP_A     = '0;
    OP_B     = '0;
  endtask

  task automatic wait_result(input logic [15:0] exp, input string tag,
                             input bit lat_chk);
    int k = 0;
    #1;
    while (!RES_VALID && k < 40) begin
      tick();
      #1;
      k++;
    end
    chk({tag, "_valid"}, RES_VALID, 1);
    if (lat_chk) chk({tag, "_lat"}, cyc - acc_cyc, EXP_LAT);
    chk({tag, "_data"}, RES_DATA, exp);
  endtask

  task automatic release_result(input string tag);
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
    #1;
    chk({tag, "_idle_busy"}, BUSY, 0);
    chk({tag, "_idle_valid"}, RES_VALID, 0);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    RST_SEQ = 1'b0;
    #1;
    chk("rst_ctrl", {BUSY, OP_READY, EN_MAC, RST_MAC, RES_VALID}, 0);
    chk("rst_bus", {BIAS_IN, A, B}, 0);
    chk("rst_data", RES_DATA, 0);
    tick();

    // Basic job: 5 + 6 - 20 + 49 = 40
    start_job(4'd3, 8'd5);
    feed_op(8'd2, 8'd3);
    feed_op(8'hFC, 8'd5);
    feed_op(8'd7, 8'd7);
    wait_result(16'h0028, "basic", 1);
    chk("basic_en_cycles", en_cnt, 4);
    chk("basic_ready_cycles", rdy_cnt, 3);
    release_result("basic");
    tick();

    // Bias-only job with OP_VALID held high: nothing accepted
    OP_VALID = 1'b1;
    OP_A = 8'd9;
    OP_B = 8'd9;
    start_job(4'd0, 8'hFF);
    wait_result(16'h00FF, "bias", 0);
    chk("bias_ready_cycles", rdy_cnt, 0);
    chk("bias_en_cycles", en_cnt, 1);
    OP_VALID = 1'b0;
    OP_A = '0;
    OP_B = '0;
    release_result("bias");
    tick();

    // Bubbles of 3 cycles between beats
    start_job(4'd3, 8'd5);
    repeat (3) tick();
    feed_op(8'd2, 8'd3);
    repeat (3) tick();
    feed_op(8'hFC, 8'd5);
    repeat (3) tick();
    feed_op(8'd7, 8'd7);
    wait_result(16'h0028, "bubble", 1);
    chk("bubble_en_cycles", en_cnt, 4);
    release_result("bubble");
    tick();

    // Negative saturation
    start_job(4'd4, 8'd0);
    repeat (4) feed_op(8'h80, 8'h7F);
    wait_result(16'h8000, "sat_neg", 1);
    release_result("sat_neg");
    tick();

    // Positive saturation
    start_job(4'd3, 8'd0);
    repeat (3) feed_op(8'h7F, 8'h7F);
    wait_result(16'h7FFF, "sat_pos", 1);
    release_result("sat_pos");
    tick();

    // Longest job: counter reaches 15 with no wrap
    start_job(4'd15, 8'd0);
    repeat (15) feed_op(8'd1, 8'd1);
    wait_result(16'h000F, "len15", 1);
    chk("len15_ready_cycles", rdy_cnt, 15);
    release_result("len15");
    tick();

    // Backpressure in DONE with START pulses
    start_job(4'd3, 8'd5);
    feed_op(8'd2, 8'd3);
    feed_op(8'hFC, 8'd5);
    feed_op(8'd7, 8'd7);
    wait_result(16'h0028, "bp", 1);
    for (int i = 0; i < 10; i++) begin
      START = (i % 3 == 0);
      LEN   = 4'd2;
      BIAS  = 8'd1;
      tick();
      #1;
      chk("bp_hold_valid", RES_VALID, 1);
      chk("bp_hold_data", RES_DATA, 16'h0028);
      chk("bp_hold_busy", BUSY, 1);
    end
    START = 1'b0;
    release_result("bp");
    tick();

    // Mid-op reset after 2 of 5 beats
    start_job(4'd5, 8'd0);
    feed_op(8'd3, 8'd3);
    feed_op(8'd3, 8'd3);
    RST_SEQ = 1'b1;
    tick();
    RST_SEQ = 1'b0;
    #1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_en", EN_MAC, 0);
    chk("mid_rst_ready", OP_READY, 0);
    tick();

    start_job(4'd3, 8'd5);
    feed_op(8'd2, 8'd3);
    feed_op(8'hFC, 8'd5);
    feed_op(8'd7, 8'd7);
    wait_result(16'h0028, "after_rst", 1);
    release_result("after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
